ymat_row_fetch: RTL and testbench

Parametrised Y-matrix row fetch engine: it accepts a row index, reads that row's start/end pointers from the row-pointer SRAM, and streams one data-SRAM address per stored nonzero over a valid/ready interface. It generalises the fixed two-address Y-matrix lookup to configurable row, address, word and pointer widths, a configurable SRAM read latency, and arbitrary row lengths, including rows whose pointers straddle two SRAM words. It sits between the row calculator and the Y-matrix data SRAM controller.

---
 rtl/ymat_pkg.sv | 26 ++
 rtl/ymat_ptr_extract.sv | 43 ++++
 rtl/ymat_row_fetch.sv | 169 ++++++++++++++++
 tb/tb_ymat_row_fetch.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ymat_pkg.sv
// ymat_pkg: definitions shared by the Y-matrix row fetch engine.
//   - default widths for the row index, data address, pointer word and field
//   - state_t : fetch engine state encoding
//   - ppw_of(): pointers per row-pointer SRAM word
package ymat_pkg;

    localparam int ROW_W_DEF  = 11;
    localparam int ADDR_W_DEF = 11;
    localparam int WORD_W_DEF = 256;
    localparam int PTR_W_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD0    = 3'd1,
        ST_WAIT0  = 3'd2,
        ST_RD1    = 3'd3,
        ST_WAIT1  = 3'd4,
        ST_STREAM = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    function automatic int ppw_of(input int word_w, input int ptr_w);
        return word_w / ptr_w;
    endfunction

endpackage

// File: rtl/ymat_ptr_extract.sv
// ymat_ptr_extract: combinational field select on one row-pointer SRAM word.
// Ports:
//   word      in  WORD_W  pointer word as returned by the SRAM
//   offset    in  OFF_W   row index modulo pointers-per-word
//   start_ptr out ADDR_W  field[offset]
//   end_ptr   out ADDR_W  field[offset+1]; only meaningful when offset is not
//                         the last field (the next word is fetched instead)
//   first_ptr out ADDR_W  field[0], the end pointer of a straddling row
module ymat_ptr_extract
    import ymat_pkg::*;
#(
    parameter  int WORD_W = WORD_W_DEF,
    parameter  int PTR_W  = PTR_W_DEF,
    parameter  int ADDR_W = ADDR_W_DEF,
    localparam int PPW    = ppw_of(WORD_W, PTR_W),
    localparam int OFF_W  = $clog2(PPW)
) (
    input  logic [WORD_W-1:0] word,
    input  logic [OFF_W-1:0]  offset,
    output logic [ADDR_W-1:0] start_ptr,
    output logic [ADDR_W-1:0] end_ptr,
    output logic [ADDR_W-1:0] first_ptr
);

    logic [ADDR_W-1:0] field [PPW];

    // Only the low ADDR_W bits of each PTR_W field carry the pointer.
    generate
        for (genvar gi = 0; gi < PPW; gi++) begin : g_field
            assign field[gi] = word[gi*PTR_W +: ADDR_W];
        end
    endgenerate

    assign start_ptr = field[offset];
    // offset+1 wraps to field 0 for the last offset; that value is ignored.
    assign end_ptr   = field[offset + 1'b1];
    assign first_ptr = field[0];

    // Upper bits of each field are intentionally ignored.
    logic unused_word_bits;
    assign unused_word_bits = ^word;

endmodule

// File: rtl/ymat_row_fetch.sv
// ymat_row_fetch: accepts a row index, reads the row's start/end pointers from
// the row-pointer SRAM (one or two words), then streams one data-SRAM address
// per nonzero over a valid/ready interface.
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   req_valid/req_row/req_ready  row request (accepted only in IDLE)
//   ptr_rd_en/ptr_rd_addr        pointer SRAM read strobe and word address
//   ptr_rd_data                  pointer word, valid RD_LAT cycles after strobe
//   addr_valid/addr_out/addr_last/addr_ready  address stream
//   done                         one-cycle pulse at end of each request
//   nnz                          end-start of last request (0 on error)
//   err                          end < start, held until the next request
module ymat_row_fetch
    import ymat_pkg::*;
#(
    parameter int ROW_W  = ROW_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORD_W = WORD_W_DEF,
    parameter int PTR_W  = PTR_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ROW_W-1:0]  req_row,
    output logic              req_ready,
    output logic              ptr_rd_en,
    output logic [ROW_W-1:0]  ptr_rd_addr,
    input  logic [WORD_W-1:0] ptr_rd_data,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_last,
    input  logic              addr_ready,
    output logic              done,
    output logic [ADDR_W-1:0] nnz,
    output logic              err
);

    localparam int PPW   = ppw_of(WORD_W, PTR_W);
    localparam int OFF_W = $clog2(PPW);
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(PPW - 1);

    state_t            state_reg;
    logic [ROW_W-1:0]  row_reg;
    logic [ADDR_W-1:0] start_reg;
    logic [ADDR_W-1:0] end_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic [OFF_W-1:0]  row_off;
    logic [ROW_W-1:0]  word_idx;
    logic [ADDR_W-1:0] ext_start, ext_end, ext_first;
    logic [ADDR_W-1:0] cap_start, cap_end;

    assign row_off  = row_reg[OFF_W-1:0];
    assign word_idx = row_reg >> OFF_W;

    ymat_ptr_extract #(
        .WORD_W (WORD_W),
        .PTR_W  (PTR_W),
        .ADDR_W (ADDR_W)
    ) u_extract (
        .word      (ptr_rd_data),
        .offset    (row_off),
        .start_ptr (ext_start),
        .end_ptr   (ext_end),
        .first_ptr (ext_first)
    );

    // Pointer pair resolved at the end of the last wait cycle: a same-word
    // row takes both from the current word, a straddling row combines the
    // start captured earlier with field 0 of the following word.
    always_comb begin
        cap_start = ext_start;
        cap_end   = ext_end;
        if (state_reg == ST_WAIT1) begin
            cap_start = start_reg;
            cap_end   = ext_first;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            row_reg     <= '0;
            start_reg   <= '0;
            end_reg     <= '0;
            cnt_reg     <= '0;
            req_ready   <= 1'b1;
            ptr_rd_en   <= 1'b0;
            ptr_rd_addr <= '0;
            addr_valid  <= 1'b0;
            addr_out    <= '0;
            addr_last   <= 1'b0;
            done        <= 1'b0;
            nnz         <= '0;
            err         <= 1'b0;
        end else begin
            ptr_rd_en <= 1'b0;
            done      <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        row_reg     <= req_row;
                        err         <= 1'b0;
                        req_ready   <= 1'b0;
                        ptr_rd_en   <= 1'b1;
                        ptr_rd_addr <= req_row >> OFF_W;
                        state_reg   <= ST_RD0;
                    end
                end
                ST_RD0: begin
                    cnt_reg   <= '0;
                    state_reg <= ST_WAIT0;
                end
                ST_WAIT0, ST_WAIT1: begin
                    if (cnt_reg != CNT_LAST) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end else if (state_reg == ST_WAIT0 && row_off == OFF_LAST) begin
                        // End pointer lives in the next word.
                        start_reg   <= ext_start;
                        ptr_rd_en   <= 1'b1;
                        ptr_rd_addr <= word_idx + 1'b1;
                        state_reg   <= ST_RD1;
                    end else begin
                        start_reg <= cap_start;
                        end_reg   <= cap_end;
                        if (cap_end <= cap_start) begin
                            err       <= (cap_end < cap_start);
                            nnz       <= '0;
                            done      <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            addr_valid <= 1'b1;
                            addr_out   <= cap_start;
                            addr_last  <= (cap_start == cap_end - 1'b1);
                            state_reg  <= ST_STREAM;
                        end
                    end
                end
                ST_RD1: begin
                    cnt_reg   <= '0;
                    state_reg <= ST_WAIT1;
                end
                ST_STREAM: begin
                    if (addr_ready) begin
                        if (addr_last) begin
                            addr_valid <= 1'b0;
                            addr_last  <= 1'b0;
                            done       <= 1'b1;
                            nnz        <= end_reg - start_reg;
                            state_reg  <= ST_DONE;
                        end else begin
                            addr_out  <= addr_out + 1'b1;
                            addr_last <= (addr_out + 1'b1 == end_reg - 1'b1);
                        end
                    end
                end
                ST_DONE: begin
                    req_ready <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ymat_row_fetch.sv
// tb_ymat_row_fetch: directed and randomized requests against two instances
// (RD_LAT=1 and RD_LAT=3) sharing one pointer memory model. Expected address
// streams, nnz, err and latencies come from the pointer-array rules.
module tb_ymat_row_fetch;

    localparam int ROW_W  = 11;
    localparam int ADDR_W = 11;
    localparam int WORD_W = 256;
    localparam int PTR_W  = 16;
    localparam int PPW    = WORD_W / PTR_W;
    localparam int NWORDS = 1 << ROW_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              req_valid;
    logic [ROW_W-1:0]  req_row;
    logic              addr_ready;
    bit                sel;   // 0: observe/drive RD_LAT=1 instance, 1: RD_LAT=3

    logic              req_valid1, req_valid3;
    logic              req_ready1, req_ready3;
    logic              ptr_rd_en1, ptr_rd_en3;
    logic [ROW_W-1:0]  ptr_rd_addr1, ptr_rd_addr3;
    logic [WORD_W-1:0] ptr_rd_data1, ptr_rd_data3;
    logic              addr_valid1, addr_valid3;
    logic [ADDR_W-1:0] addr_out1, addr_out3;
    logic              addr_last1, addr_last3;
    logic              done1, done3;
    logic [ADDR_W-1:0] nnz1, nnz3;
    logic              err1, err3;

    assign req_valid1 = req_valid & ~sel;
    assign req_valid3 = req_valid & sel;

    ymat_row_fetch #(.ROW_W(ROW_W), .ADDR_W(ADDR_W), .WORD_W(WORD_W), .PTR_W(PTR_W), .RD_LAT(1)) dut (
        .clock(clk), .reset(reset), .req_valid(req_valid1), .req_row(req_row),
        .req_ready(req_ready1), .ptr_rd_en(ptr_rd_en1), .ptr_rd_addr(ptr_rd_addr1),
        .ptr_rd_data(ptr_rd_data1), .addr_valid(addr_valid1), .addr_out(addr_out1),
        .addr_last(addr_last1), .addr_ready(addr_ready), .done(done1), .nnz(nnz1), .err(err1));

    ymat_row_fetch #(.ROW_W(ROW_W), .ADDR_W(ADDR_W), .WORD_W(WORD_W), .PTR_W(PTR_W), .RD_LAT(3)) dut3 (
        .clock(clk), .reset(reset), .req_valid(req_valid3), .req_row(req_row),
        .req_ready(req_ready3), .ptr_rd_en(ptr_rd_en3), .ptr_rd_addr(ptr_rd_addr3),
        .ptr_rd_data(ptr_rd_data3), .addr_valid(addr_valid3), .addr_out(addr_out3),
        .addr_last(addr_last3), .addr_ready(addr_ready), .done(done3), .nnz(nnz3), .err(err3));

    // Observed view of the selected instance
    logic              v_req_ready, v_ptr_rd_en, v_addr_valid, v_addr_last, v_done, v_err;
    logic [ROW_W-1:0]  v_ptr_rd_addr;
    logic [ADDR_W-1:0] v_addr_out, v_nnz;
    assign v_req_ready   = sel ? req_ready3   : req_ready1;
    assign v_ptr_rd_en   = sel ? ptr_rd_en3   : ptr_rd_en1;
    assign v_ptr_rd_addr = sel ? ptr_rd_addr3 : ptr_rd_addr1;
    assign v_addr_valid  = sel ? addr_valid3  : addr_valid1;
    assign v_addr_out    = sel ? addr_out3    : addr_out1;
    assign v_addr_last   = sel ? addr_last3   : addr_last1;
    assign v_done        = sel ? done3        : done1;
    assign v_nnz         = sel ? nnz3         : nnz1;
    assign v_err         = sel ? err3         : err1;

    // Pointer SRAM model: garbage on the bus except exactly RD_LAT cycles after a read.
    logic [WORD_W-1:0] mem [NWORDS];
    logic [WORD_W-1:0] p3_s0, p3_s1;

    function automatic logic [WORD_W-1:0] rnd_word();
        logic [WORD_W-1:0] w;
        for (int i = 0; i < WORD_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    always @(posedge clk) begin
        ptr_rd_data1 <= ptr_rd_en1 ? mem[ptr_rd_addr1] : rnd_word();
        p3_s0        <= ptr_rd_en3 ? mem[ptr_rd_addr3] : rnd_word();
        p3_s1        <= p3_s0;
        ptr_rd_data3 <= p3_s1;
    end

    int checks = 0;
    int errors = 0;
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pointer array view: ptr[r] = low ADDR_W bits of field r%PPW of word r/PPW.
    function automatic int get_ptr(input int r);
        logic [WORD_W-1:0] w;
        logic [ADDR_W-1:0] f;
        w = mem[r / PPW];
        f = w[(r % PPW) * PTR_W +: ADDR_W];
        return int'(f);
    endfunction

    task automatic set_ptr(input int r, input int v);
        logic [WORD_W-1:0] w;
        logic [PTR_W-1:0]  f;
        f = PTR_W'($urandom);
        f[ADDR_W-1:0] = ADDR_W'(v);
        w = mem[r / PPW];
        w[(r % PPW) * PTR_W +: PTR_W] = f;
        mem[r / PPW] = w;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, v_req_ready, 1);
        chk({tag, "_ptr_rd_en"}, v_ptr_rd_en, 0);
        chk({tag, "_ptr_rd_addr"}, v_ptr_rd_addr, 0);
        chk({tag, "_addr_valid"}, v_addr_valid, 0);
        chk({tag, "_addr_out"}, v_addr_out, 0);
        chk({tag, "_addr_last"}, v_addr_last, 0);
        chk({tag, "_done"}, v_done, 0);
        chk({tag, "_nnz"}, v_nnz, 0);
        chk({tag, "_err"}, v_err, 0);
    endtask

    // mode 0: addr_ready always 1; 1: random; 2: fixed toggle pattern
    task automatic do_req(input int r, input int mode);
        int lat, exp_s, exp_e, n, strad, cyc, beats, first_cyc, last_hs, done_cyc, pidx, exp_lat;
        bit exp_err, prev_stall, rdy;
        logic [ADDR_W-1:0] prev_addr;
        logic prev_last;
        int rd_addrs[$];
        int rd_cycs[$];
        lat     = sel ? 3 : 1;
        exp_s   = get_ptr(r);
        exp_e   = get_ptr(r + 1);
        exp_err = (exp_e < exp_s);
        n       = exp_err ? 0 : exp_e - exp_s;
        strad   = ((r % PPW) == PPW - 1) ? 1 : 0;
        exp_lat = 2 + lat + strad * (lat + 1);

        @(negedge clk);
        chk("req_ready_idle", v_req_ready, 1);
        req_valid = 1'b1;
        req_row   = ROW_W'(r);
        cyc = 0; beats = 0; first_cyc = -1; last_hs = -1; done_cyc = -1; pidx = 0;
        prev_stall = 1'b0; prev_addr = '0; prev_last = 1'b0;
        while (done_cyc < 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("err_cleared", v_err, 0);
                chk("req_ready_busy", v_req_ready, 0);
            end
            if (v_ptr_rd_en) begin
                rd_addrs.push_back(int'(v_ptr_rd_addr));
                rd_cycs.push_back(cyc);
            end
            if (prev_stall) begin
                chk("stall_valid", v_addr_valid, 1);
                chk("stall_addr", v_addr_out, prev_addr);
                chk("stall_last", v_addr_last, prev_last);
            end
            if (v_addr_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = 1'($urandom_range(0, 1));
                    default: rdy = (pidx < 7) ? pat[pidx] : 1'b1;
                endcase
                pidx++;
                addr_ready = rdy;
                if (rdy) begin
                    chk("beat_addr", v_addr_out, (exp_s + beats) % (1 << ADDR_W));
                    chk("beat_last", v_addr_last, (beats == n - 1) ? 1 : 0);
                    beats++;
                    last_hs = cyc;
                end
                prev_stall = !rdy;
                prev_addr  = v_addr_out;
                prev_last  = v_addr_last;
            end else begin
                addr_ready = 1'($urandom_range(0, 1));
                prev_stall = 1'b0;
            end
            if (v_done) begin
                done_cyc = cyc;
                chk("done_no_valid", v_addr_valid, 0);
            end
            // Requests outside IDLE must be ignored; stop driving once done is seen.
            req_valid = (done_cyc < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_row   = ROW_W'($urandom);
        end
        req_valid  = 1'b0;
        addr_ready = 1'b0;

        if (done_cyc < 0) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("nnz", v_nnz, n);
            chk("err", v_err, exp_err);
            chk("beat_count", beats, n);
            chk("rd_count", rd_addrs.size(), 1 + strad);
            if (rd_addrs.size() >= 1) begin
                chk("rd0_addr", rd_addrs[0], r / PPW);
                chk("rd0_cycle", rd_cycs[0], 1);
            end
            if (strad == 1 && rd_addrs.size() >= 2) begin
                chk("rd1_addr", rd_addrs[1], ((r / PPW) + 1) % NWORDS);
                chk("rd1_cycle", rd_cycs[1], 2 + lat);
            end
            if (n == 0) begin
                chk("no_stream", first_cyc, -1);
                chk("empty_done_cycle", done_cyc, exp_lat);
            end else begin
                chk("first_valid_cycle", first_cyc, exp_lat);
                chk("done_after_last", done_cyc, last_hs + 1);
                if (mode == 0) chk("full_throughput", last_hs, first_cyc + n - 1);
            end
            @(negedge clk);
            chk("done_one_cycle", v_done, 0);
            chk("ready_after_done", v_req_ready, 1);
            chk("err_held", v_err, exp_err);
        end
        $display("req lat=%0d row=%0d start=%0d end=%0d beats=%0d nnz=%0d err=%0d done_cyc=%0d",
                 lat, r, exp_s, exp_e, beats, v_nnz, v_err, done_cyc);
    endtask

    task automatic do_random(input int count);
        int r, s, e, kind;
        for (int i = 0; i < count; i++) begin
            if ($urandom_range(0, 3) == 0) r = $urandom_range(0, 126) * PPW + (PPW - 1);
            else                           r = $urandom_range(0, NWORDS - 2);
            s    = $urandom_range(0, 2000);
            kind = $urandom_range(0, 9);
            if (kind == 0 && s > 0) e = s - $urandom_range(1, (s < 5) ? s : 5);
            else if (kind == 1)     e = s;
            else                    e = s + $urandom_range(1, 8);
            set_ptr(r, s);
            set_ptr(r + 1, e);
            do_req(r, 1);
        end
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < NWORDS; i++) mem[i] = rnd_word();
        sel        = 1'b0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_row    = '0;
        addr_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("reset");

        // Same-word row, 4 beats
        set_ptr(3, 10); set_ptr(4, 14);
        do_req(3, 0);
        // Straddling row
        set_ptr(15, 40); set_ptr(16, 42);
        do_req(15, 0);
        // Empty row
        set_ptr(5, 7); set_ptr(6, 7);
        do_req(5, 0);
        // Reversed pointers
        set_ptr(6, 20); set_ptr(7, 18);
        do_req(6, 0);
        // Next request clears err; stalls with a fixed ready pattern
        do_req(3, 2);

        // Reset in the middle of a stream
        @(negedge clk);
        req_valid = 1'b1; req_row = 3; addr_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (v_addr_valid && v_addr_out == 11) seen = 1'b1;
        end
        chk("mid_reached_11", seen, 1);
        @(negedge clk);
        chk("mid_addr_12", v_addr_out, 12);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; addr_ready = 1'b0;
        chk_idle_outputs("mid_reset");
        @(negedge clk);
        chk("mid_no_done", v_done, 0);
        chk("mid_ready", v_req_ready, 1);
        do_req(3, 0);

        do_random(40);

        // RD_LAT=3 instance
        sel   = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("lat3_reset");
        do_req(3, 0);
        do_req(15, 0);
        do_req(5, 0);
        do_req(3, 2);
        do_random(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
